// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle, with
// optional two's-complement input, sign output and saturation on overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  input  logic                  signed_mode,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow,
  output logic                  ready,
  output logic                  done
);

  // One spare digit beyond ceil(BIN_W*log10(2)) keeps the top digit below 5,
  // so the shift never drops a bit before the overflow check.
  localparam int SCR_DIG = (BIN_W * 30103 + 99999) / 100000 + 1;
  localparam int SCR_W   = 4 * SCR_DIG;
  localparam int MAX_DIG = (SCR_DIG > DIGITS) ? SCR_DIG : DIGITS;
  localparam int EXT_W   = 4 * MAX_DIG;
  localparam int CNT_W   = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [SCR_W-1:0]    scr, scr_nxt;
  logic [BIN_W-1:0]    mag, mag_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                last_iter;
  logic signed [BIN_W-1:0] bin_s;
  logic [BIN_W-1:0]    mag_in;
  logic                neg_in;
  logic [4*DIGITS:0]   sat;

  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int i = 0; i < SCR_DIG; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Returns {overflow, digits}; clamps to all nines when upper digits are set.
  function automatic logic [4*DIGITS:0] saturate(input logic [SCR_W-1:0] s);
    logic [EXT_W-1:0] ext;
    logic             ovf;
    ext = EXT_W'(s);
    ovf = 1'b0;
    for (int i = DIGITS; i < MAX_DIG; i++) begin
      if (ext[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    if (ovf) return {1'b1, {DIGITS{4'h9}}};
    return {1'b0, ext[4*DIGITS-1:0]};
  endfunction

  // Most-negative input negates to 2^(BIN_W-1), still exact as unsigned.
  assign bin_s     = binary;
  assign neg_in    = signed_mode & binary[BIN_W-1];
  assign mag_in    = neg_in ? $unsigned(-bin_s) : binary;
  assign last_iter = (cnt == LAST);
  assign ready     = (state == IDLE);

  always_comb begin
    {scr_nxt, mag_nxt} = {add3(scr), mag} << 1;
    sat = saturate(scr_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      scr <= '0;
      mag <= mag_in;
      neg <= neg_in;
    end else if (state == SHIFT) begin
      scr <= scr_nxt;
      mag <= mag_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd      <= '0;
      sign     <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == SHIFT) && last_iter;
      if (state == SHIFT && last_iter) begin
        {overflow, bcd} <= sat;
        sign            <= neg & (scr_nxt != '0);
      end
    end
  end

endmodule
